// File: rtl/event_read_if.sv
// Handshake bundle between the event read controller, the event memory
// and the tower builder. The controller takes the slave view.
interface event_read_if #(
   parameter int MEMORY_ADDR_LENGTH = 20,
   parameter int DATA_WIDTH         = 32
);
   logic                          start;
   logic [MEMORY_ADDR_LENGTH-1:0] bottom_addr;
   logic [MEMORY_ADDR_LENGTH-1:0] top_addr;
   logic                          busy;
   logic                          addr_error;
   logic                          mem_rd_en;
   logic [MEMORY_ADDR_LENGTH-1:0] mem_addr;
   logic                          mem_rd_valid;
   logic [DATA_WIDTH-1:0]         mem_rd_data;
   logic                          cell_valid;
   logic [DATA_WIDTH-1:0]         cell_data;
   logic                          cell_last;
   logic                          cell_ready;
   logic                          event_done;

   modport slave (
      input  start, bottom_addr, top_addr, mem_rd_valid, mem_rd_data, cell_ready,
      output busy, addr_error, mem_rd_en, mem_addr, cell_valid, cell_data, cell_last,
             event_done
   );

   modport master (
      output start, bottom_addr, top_addr, mem_rd_valid, mem_rd_data, cell_ready,
      input  busy, addr_error, mem_rd_en, mem_addr, cell_valid, cell_data, cell_last,
             event_done
   );
endinterface

// File: rtl/event_read_ctrl.sv
// Reads one event (bottom_addr..top_addr) from event memory and streams the
// cell records, in address order, through a small return FIFO to the tower builder.
module event_read_ctrl #(
   parameter int MEMORY_ADDR_LENGTH = 20,
   parameter int DATA_WIDTH         = 32,
   parameter int FIFO_DEPTH         = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   event_read_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]                    state_q, state_d;
   logic [MEMORY_ADDR_LENGTH-1:0] addr_q, addr_d;
   logic [MEMORY_ADDR_LENGTH-1:0] top_q, top_d;
   logic [CNT_W-1:0]              out_q, out_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
   logic                          addr_error_q, addr_error_d;
   logic [DATA_WIDTH-1:0]         fifo_data_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]         fifo_last_q;

   logic [CNT_W:0] inflight;
   logic           fifo_ne;
   logic           rd_req;
   logic           ret_acc;
   logic           push_last;
   logic           pop;

   always_comb begin
      fifo_ne  = (cnt_q != '0);
      inflight = {1'b0, out_q} + {1'b0, cnt_q};
      // Reads in flight reserve FIFO space, so the FIFO can never overflow.
      rd_req   = (state_q == FETCH) && (inflight < {1'b0, DEPTH_C});
      ret_acc  = bus.mem_rd_valid && (out_q != '0);
      // Returns arrive in order and DRAIN issues no reads: the final one is top_addr.
      push_last = ret_acc && (state_q == DRAIN) && (out_q == CNT_W'(1));
      pop      = fifo_ne && bus.cell_ready;

      out_d = out_q;
      if (rd_req && !ret_acc) begin
         out_d = out_q + 1'b1;
      end else if (!rd_req && ret_acc) begin
         out_d = out_q - 1'b1;
      end

      cnt_d = cnt_q;
      if (ret_acc && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!ret_acc && pop) begin
         cnt_d = cnt_q - 1'b1;
      end

      wr_ptr_d = ret_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      top_d        = top_q;
      addr_error_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.bottom_addr <= bus.top_addr) begin
                  addr_d  = bus.bottom_addr;
                  top_d   = bus.top_addr;
                  state_d = FETCH;
               end else begin
                  addr_error_d = 1'b1;
               end
            end
         end
         FETCH: begin
            if (rd_req) begin
               addr_d = addr_q + 1'b1;
               // Compare before the increment so an all-ones top never wraps.
               if (addr_q == top_q) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if ((out_d == '0) && (cnt_d == '0)) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         out_q        <= '0;
         cnt_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         addr_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_q        <= out_d;
         cnt_q        <= cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         addr_error_q <= addr_error_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      top_q  <= top_d;
      if (ret_acc) begin
         fifo_data_q[wr_ptr_q] <= bus.mem_rd_data;
         fifo_last_q[wr_ptr_q] <= push_last;
      end
   end

   // Outputs are forced to their idle values while reset is held.
   assign bus.busy       = rst_n && (state_q != IDLE);
   assign bus.addr_error = rst_n && addr_error_q;
   assign bus.mem_rd_en  = rst_n && rd_req;
   assign bus.mem_addr   = bus.mem_rd_en ? addr_q : '0;
   assign bus.cell_valid = rst_n && fifo_ne;
   assign bus.cell_data  = bus.cell_valid ? fifo_data_q[rd_ptr_q] : '0;
   assign bus.cell_last  = bus.cell_valid && fifo_last_q[rd_ptr_q];
   assign bus.event_done = rst_n && (state_q == DONE);
endmodule

// File: tb/tb_event_read_ctrl.sv
// Directed bench for event_read_ctrl: memory model with configurable latency,
// expected reads and records queued at stimulus time, checked by a monitor.
module tb_event_read_ctrl;
   logic clk;
   logic rst_n;

   event_read_if #(.MEMORY_ADDR_LENGTH(20), .DATA_WIDTH(32)) bus ();

   event_read_ctrl #(
      .MEMORY_ADDR_LENGTH(20),
      .DATA_WIDTH(32),
      .FIFO_DEPTH(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int lat         = 3;
   int rd_count    = 0;
   int done_cnt    = 0;
   int err_cnt     = 0;
   int last_xfer_cyc = -10;

   logic [19:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic        exp_last[$];
   logic [19:0] pend_a[$];
   int          pend_due[$];

   function automatic logic [31:0] mkdata(logic [19:0] a);
      return {12'hA5C, a};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(string name, logic [63:0] act);
      vectors++;
      miscompares++;
      $display("FAIL %s: got %0h, expected nothing", name, act);
   endtask

   // Event memory: one word per request, in order, lat cycles later.
   initial begin
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = '0;
      forever begin
         @(posedge clk);
         cyc++;
         if (bus.mem_rd_en) begin
            pend_a.push_back(bus.mem_addr);
            pend_due.push_back(cyc + lat - 1);
            rd_count++;
         end
         #1;
         if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = mkdata(pend_a.pop_front());
            void'(pend_due.pop_front());
         end else begin
            bus.mem_rd_valid = 1'b0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents something.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mem_rd_en) begin
            if (exp_addr.size() == 0) flag("unexpected_read", 64'(bus.mem_addr));
            else check("read_addr", 64'(bus.mem_addr), 64'(exp_addr.pop_front()));
         end
         if (bus.cell_valid && !bus.cell_ready && exp_data.size() > 0) begin
            check("held_data", 64'(bus.cell_data), 64'(exp_data[0]));
            check("held_last", 64'(bus.cell_last), 64'(exp_last[0]));
         end
         if (bus.cell_valid && bus.cell_ready) begin
            if (exp_data.size() == 0) begin
               flag("unexpected_record", 64'(bus.cell_data));
            end else begin
               logic el;
               el = exp_last.pop_front();
               check("cell_data", 64'(bus.cell_data), 64'(exp_data.pop_front()));
               check("cell_last", 64'(bus.cell_last), 64'(el));
               if (el) last_xfer_cyc = cyc;
            end
         end
         if (bus.event_done) begin
            done_cnt++;
            check("done_timing", 64'(cyc), 64'(last_xfer_cyc + 1));
         end
         if (bus.addr_error) err_cnt++;
      end
   end

   task automatic push_event(logic [19:0] bot, logic [19:0] top);
      for (int a = int'(bot); a <= int'(top); a++) begin
         exp_addr.push_back(20'(a));
         exp_data.push_back(mkdata(20'(a)));
         exp_last.push_back(a == int'(top));
      end
   endtask

   task automatic do_start(logic [19:0] bot, logic [19:0] top);
      @(posedge clk); #1;
      bus.start       = 1'b1;
      bus.bottom_addr = bot;
      bus.top_addr    = top;
      @(posedge clk); #1;
      bus.start       = 1'b0;
   endtask

   task automatic wait_done(string name, int budget);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      check({name, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
      check({name, "_records_left"}, 64'(exp_data.size()), 64'd0);
      check({name, "_reads_left"}, 64'(exp_addr.size()), 64'd0);
      check({name, "_idle_after"}, 64'(bus.busy), 64'd0);
   endtask

   task automatic check_reset_outputs(string name);
      check({name, "_busy"}, 64'(bus.busy), 64'd0);
      check({name, "_addr_error"}, 64'(bus.addr_error), 64'd0);
      check({name, "_mem_rd_en"}, 64'(bus.mem_rd_en), 64'd0);
      check({name, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
      check({name, "_cell_valid"}, 64'(bus.cell_valid), 64'd0);
      check({name, "_cell_data"}, 64'(bus.cell_data), 64'd0);
      check({name, "_cell_last"}, 64'(bus.cell_last), 64'd0);
      check({name, "_event_done"}, 64'(bus.event_done), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int e0;
      int d0;
      int bcnt;
      int n;
      rst_n           = 1'b0;
      bus.start       = 1'b0;
      bus.bottom_addr = '0;
      bus.top_addr    = '0;
      bus.cell_ready  = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 64'(bus.busy), 64'd0);

      // Eight-word event, latency 3
      lat = 3;
      r0  = rd_count;
      push_event(20'h00010, 20'h00017);
      do_start(20'h00010, 20'h00017);
      wait_done("ev8", 200);
      check("ev8_reads", 64'(rd_count - r0), 64'd8);

      // Single-word event
      r0 = rd_count;
      push_event(20'h00005, 20'h00005);
      do_start(20'h00005, 20'h00005);
      wait_done("ev1", 100);
      check("ev1_reads", 64'(rd_count - r0), 64'd1);

      // Reversed range is rejected
      r0   = rd_count;
      e0   = err_cnt;
      bcnt = 0;
      do_start(20'h00020, 20'h0001F);
      repeat (6) begin
         @(negedge clk);
         if (bus.busy) bcnt++;
      end
      check("bad_range_addr_error_cycles", 64'(err_cnt - e0), 64'd1);
      check("bad_range_reads", 64'(rd_count - r0), 64'd0);
      check("bad_range_busy_cycles", 64'(bcnt), 64'd0);

      // Sixteen-word event with the consumer stalled for 20 cycles
      bus.cell_ready = 1'b0;
      r0 = rd_count;
      push_event(20'h00100, 20'h0010F);
      do_start(20'h00100, 20'h0010F);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("stall_reads", 64'(rd_count - r0), 64'd4);
      check("stall_rd_en", 64'(bus.mem_rd_en), 64'd0);
      check("stall_valid", 64'(bus.cell_valid), 64'd1);
      check("stall_head", 64'(bus.cell_data), 64'h00000000A5C00100);
      @(posedge clk); #1;
      bus.cell_ready = 1'b1;
      wait_done("ev16", 400);
      check("ev16_reads", 64'(rd_count - r0), 64'd16);

      // Top of the address space, no wrap
      r0 = rd_count;
      push_event(20'hFFFFE, 20'hFFFFF);
      do_start(20'hFFFFE, 20'hFFFFF);
      wait_done("evtop", 100);
      check("evtop_reads", 64'(rd_count - r0), 64'd2);

      // Reset after three reads with returns still in flight
      lat            = 4;
      bus.cell_ready = 1'b0;
      r0             = rd_count;
      d0             = done_cnt;
      push_event(20'h00040, 20'h00047);
      do_start(20'h00040, 20'h00047);
      n = 0;
      while ((rd_count - r0) < 3 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("abort_reads_before_reset", 64'(rd_count - r0), 64'd3);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("abort");
      rst_n = 1'b1;
      exp_addr.delete();
      exp_data.delete();
      exp_last.delete();
      bus.cell_ready = 1'b1;
      bcnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.cell_valid || bus.event_done || bus.busy) bcnt++;
      end
      check("abort_quiet_cycles", 64'(bcnt), 64'd0);
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);
      check("abort_read_total", 64'(rd_count - r0), 64'd3);

      // Normal event after the abort
      lat = 3;
      r0  = rd_count;
      push_event(20'h00050, 20'h00053);
      do_start(20'h00050, 20'h00053);
      wait_done("post_abort", 100);
      check("post_abort_reads", 64'(rd_count - r0), 64'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
